jt5205_adpcm_enc: RTL and testbench

//  4-bit OKI/Dialogic ADPCM encoder: the inverse of the jt5205 decode path. Takes 12-bit signed PCM,

---
 rtl/jt5205_pkg.sv | 47 ++++
 rtl/jt5205_adpcm_enc_if.sv | 24 ++
 rtl/jt5205_adpcm_step.sv | 57 +++++
 rtl/jt5205_adpcm_enc.sv | 154 +++++++++++++++
 tb/tb_jt5205_adpcm_enc.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/jt5205_pkg.sv
// Shared jt5205 ADPCM constants: step table, index adjust table, widths and encoder states.
// The decoder imports this package too, so the tables cannot diverge between the two paths.
package jt5205_pkg;

    localparam int unsigned PCM_W     = 12;
    localparam int unsigned DIFF_W    = PCM_W + 1;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned STEP_W    = 12;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned IDX_SUM_W = IDX_W + 2;
    localparam int unsigned ADJ_W     = 5;
    localparam int unsigned DELTA_W   = 14;
    localparam int unsigned STEP_N    = 49;

    typedef logic signed [PCM_W-1:0] pcm_t;
    typedef logic [STEP_W-1:0]       step_t;
    typedef logic [IDX_W-1:0]        idx_t;
    typedef logic [NIB_W-1:0]        nib_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B2,
        ST_B1,
        ST_B0,
        ST_UPD
    } enc_state_t;

    localparam idx_t IDX_MAX = 6'd48;
    localparam pcm_t PCM_MAX = 12'sh7FF;
    localparam pcm_t PCM_MIN = 12'sh800;

    localparam step_t STEP_TAB [0:STEP_N-1] = '{
        12'd16,   12'd17,   12'd19,   12'd21,   12'd23,   12'd25,   12'd28,
        12'd31,   12'd34,   12'd37,   12'd41,   12'd45,   12'd50,   12'd55,
        12'd60,   12'd66,   12'd73,   12'd80,   12'd88,   12'd97,   12'd107,
        12'd118,  12'd130,  12'd143,  12'd157,  12'd173,  12'd190,  12'd209,
        12'd230,  12'd253,  12'd279,  12'd307,  12'd337,  12'd371,  12'd408,
        12'd449,  12'd494,  12'd544,  12'd598,  12'd658,  12'd724,  12'd796,
        12'd876,  12'd963,  12'd1060, 12'd1166, 12'd1282, 12'd1411, 12'd1552
    };

    // Indexed by the magnitude bits {b2,b1,b0}.
    localparam logic signed [ADJ_W-1:0] ADJ_TAB [0:7] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
    };

endpackage

// File: rtl/jt5205_adpcm_enc_if.sv
// PCM-in / nibble-out handshake bundle for the jt5205 ADPCM encoder.
interface jt5205_adpcm_enc_if;
    import jt5205_pkg::*;

    pcm_t pcm_in;
    logic pcm_valid;
    logic pcm_ready;
    nib_t nib;
    logic nib_valid;
    logic nib_ready;

    // Caller side: supplies samples, consumes nibbles.
    modport master (
        output pcm_in, pcm_valid, nib_ready,
        input  pcm_ready, nib, nib_valid
    );

    // Encoder side.
    modport slave (
        input  pcm_in, pcm_valid, nib_ready,
        output pcm_ready, nib, nib_valid
    );

endinterface

// File: rtl/jt5205_adpcm_step.sv
// Step-index tracker: clamps idx after each update and looks up the step size from the ROM.
// Optional idx output exists only when JT5205_ADPCM_ENC_DBG_EN is defined.
module jt5205_adpcm_step
    import jt5205_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_tick,
    input  logic       upd,
    input  logic [2:0] mag_code,
`ifdef JT5205_ADPCM_ENC_DBG_EN
    output idx_t       idx,
`endif
    output step_t      step
);

    localparam logic signed [IDX_SUM_W-1:0] SUM_MAX = IDX_SUM_W'(IDX_MAX);

    idx_t  idx_q, idx_d;
    step_t step_q;

    function automatic idx_t clamp_idx(input idx_t cur, input logic [2:0] code);
        logic signed [IDX_SUM_W-1:0] sum;
        sum = $signed({2'b00, cur}) + IDX_SUM_W'(ADJ_TAB[code]);
        if (sum[IDX_SUM_W-1])
            return '0;
        else if (sum > SUM_MAX)
            return IDX_MAX;
        else
            return sum[IDX_W-1:0];
    endfunction

    always_comb begin
        idx_d = idx_q;
        if (clr_tick)
            idx_d = '0;
        else if (upd)
            idx_d = clamp_idx(idx_q, mag_code);
    end

    // ROM addressed by the next index so step always matches the registered idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            step_q <= STEP_TAB[0];
        end else begin
            idx_q  <= idx_d;
            step_q <= STEP_TAB[idx_d];
        end
    end

    assign step = step_q;
`ifdef JT5205_ADPCM_ENC_DBG_EN
    assign idx  = idx_q;
`endif

endmodule

// File: rtl/jt5205_adpcm_enc.sv
// 4-bit OKI ADPCM encoder tracking the jt5205 decoder predictor bit-exactly, one bit per cen tick.
// Define JT5205_ADPCM_ENC_DBG_EN to expose pred_dbg/idx_dbg.
module jt5205_adpcm_enc
    import jt5205_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic clr,
    jt5205_adpcm_enc_if.slave bus
`ifdef JT5205_ADPCM_ENC_DBG_EN
    ,
    output pcm_t pred_dbg,
    output idx_t idx_dbg
`endif
);

    localparam logic signed [DELTA_W-1:0] SUM_MAX = DELTA_W'(PCM_MAX);
    localparam logic signed [DELTA_W-1:0] SUM_MIN = DELTA_W'(PCM_MIN);

    enc_state_t state_q, state_d;
    pcm_t       pred_q, pred_d;
    step_t      mag_q, mag_d;
    logic       sign_q, sign_d;
    logic       b2_q, b2_d, b1_q, b1_d, b0_q, b0_d;
    nib_t       nib_q, nib_d;
    logic       nib_valid_q, nib_valid_d;

    step_t                     step, step_half, step_qtr;
    logic                      upd_fire, stall, clr_tick;
    logic signed [DIFF_W-1:0]  diff;
    logic        [DIFF_W-1:0]  diff_abs;
    logic signed [DELTA_W-1:0] delta, pred_ext, pred_sum;
    pcm_t                      pred_sat;

    assign clr_tick = cen & clr;
    assign stall    = nib_valid_q & ~bus.nib_ready;

    jt5205_adpcm_step u_step (
        .clk      (clk),
        .rst      (rst),
        .clr_tick (clr_tick),
        .upd      (upd_fire),
        .mag_code ({b2_q, b1_q, b0_q}),
`ifdef JT5205_ADPCM_ENC_DBG_EN
        .idx      (idx_dbg),
`endif
        .step     (step)
    );

    // Difference magnitude and decoder-identical reconstruction with saturation.
    always_comb begin
        diff      = $signed({bus.pcm_in[PCM_W-1], bus.pcm_in}) - $signed({pred_q[PCM_W-1], pred_q});
        diff_abs  = diff[DIFF_W-1] ? DIFF_W'(-diff) : DIFF_W'(diff);
        step_half = step >> 1;
        step_qtr  = step >> 2;
        delta     = DELTA_W'(step >> 3)
                  + (b2_q ? DELTA_W'(step)      : '0)
                  + (b1_q ? DELTA_W'(step_half) : '0)
                  + (b0_q ? DELTA_W'(step_qtr)  : '0);
        pred_ext  = DELTA_W'(pred_q);
        pred_sum  = sign_q ? (pred_ext - delta) : (pred_ext + delta);
        if (pred_sum > SUM_MAX)
            pred_sat = PCM_MAX;
        else if (pred_sum < SUM_MIN)
            pred_sat = PCM_MIN;
        else
            pred_sat = pred_sum[PCM_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        mag_d       = mag_q;
        sign_d      = sign_q;
        b2_d        = b2_q;
        b1_d        = b1_q;
        b0_d        = b0_q;
        nib_d       = nib_q;
        nib_valid_d = nib_valid_q;
        upd_fire    = 1'b0;
        if (cen) begin
            // An accepted nibble frees the slot; a same-tick UPD load below overrides this.
            if (nib_valid_q && bus.nib_ready)
                nib_valid_d = 1'b0;
            if (clr) begin
                state_d = ST_IDLE;
                pred_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: if (bus.pcm_valid) begin
                        sign_d  = diff[DIFF_W-1];
                        mag_d   = diff_abs[STEP_W-1:0];
                        state_d = ST_B2;
                    end
                    ST_B2: begin
                        b2_d = (mag_q >= step);
                        if (b2_d) mag_d = mag_q - step;
                        state_d = ST_B1;
                    end
                    ST_B1: begin
                        b1_d = (mag_q >= step_half);
                        if (b1_d) mag_d = mag_q - step_half;
                        state_d = ST_B0;
                    end
                    ST_B0: begin
                        b0_d    = (mag_q >= step_qtr);
                        state_d = ST_UPD;
                    end
                    ST_UPD: if (!stall) begin
                        pred_d      = pred_sat;
                        nib_d       = {sign_q, b2_q, b1_q, b0_q};
                        nib_valid_d = 1'b1;
                        upd_fire    = 1'b1;
                        state_d     = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pred_q      <= '0;
            mag_q       <= '0;
            sign_q      <= 1'b0;
            b2_q        <= 1'b0;
            b1_q        <= 1'b0;
            b0_q        <= 1'b0;
            nib_q       <= '0;
            nib_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            mag_q       <= mag_d;
            sign_q      <= sign_d;
            b2_q        <= b2_d;
            b1_q        <= b1_d;
            b0_q        <= b0_d;
            nib_q       <= nib_d;
            nib_valid_q <= nib_valid_d;
        end
    end

    assign bus.pcm_ready = (state_q == ST_IDLE) & ~clr;
    assign bus.nib       = nib_q;
    assign bus.nib_valid = nib_valid_q;
`ifdef JT5205_ADPCM_ENC_DBG_EN
    assign pred_dbg      = pred_q;
`endif

endmodule

// File: tb/tb_jt5205_adpcm_enc.sv
// Scoreboard bench for jt5205_adpcm_enc: an encode/decode reference model predicts every nibble.
// With JT5205_ADPCM_ENC_DBG_EN defined, predictor and index are also compared per nibble.
module tb_jt5205_adpcm_enc;

    localparam int STEP_TB [49] = '{
        16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66, 73, 80, 88, 97,
        107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279, 307, 337, 371, 408, 449,
        494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552
    };
    localparam int ADJ_TB [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

    typedef struct {
        logic [3:0] code;
        int         pred;
        int         idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst, cen, clr;
    always #5 clk = ~clk;

    jt5205_adpcm_enc_if bus ();

`ifdef JT5205_ADPCM_ENC_DBG_EN
    logic [11:0] pred_dbg;
    logic [5:0]  idx_dbg;
`endif

    jt5205_adpcm_enc dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .clr      (clr),
        .bus      (bus)
`ifdef JT5205_ADPCM_ENC_DBG_EN
        ,
        .pred_dbg (pred_dbg),
        .idx_dbg  (idx_dbg)
`endif
    );

    exp_t sb[$];
    int   m_pred, m_idx;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   accepted;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: encode against the model predictor, then rebuild it the way the decoder does.
    task automatic model_enc(input int pcm, output exp_t e);
        int step, diff, mag, delta;
        logic b2, b1, b0;
        step = STEP_TB[m_idx];
        diff = pcm - m_pred;
        mag  = (diff < 0) ? -diff : diff;
        b2 = (mag >= step);
        if (b2) mag -= step;
        b1 = (mag >= step / 2);
        if (b1) mag -= step / 2;
        b0 = (mag >= step / 4);
        delta = step / 8 + (b2 ? step : 0) + (b1 ? step / 2 : 0) + (b0 ? step / 4 : 0);
        m_pred = (diff < 0) ? m_pred - delta : m_pred + delta;
        if (m_pred > 2047)  m_pred = 2047;
        if (m_pred < -2048) m_pred = -2048;
        m_idx += ADJ_TB[{b2, b1, b0}];
        if (m_idx < 0)  m_idx = 0;
        if (m_idx > 48) m_idx = 48;
        e.code = {diff < 0, b2, b1, b0};
        e.pred = m_pred;
        e.idx  = m_idx;
    endtask

    // One clock: observe the transfers that the coming edge will perform, then advance.
    task automatic cycle();
        exp_t e;
        #1;
        if (cen && bus.nib_valid && bus.nib_ready) begin
            check_eq("nib_pending", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("nib", int'(bus.nib), int'(e.code));
`ifdef JT5205_ADPCM_ENC_DBG_EN
                check_eq("pred_dbg", int'($signed(pred_dbg)), e.pred);
                check_eq("idx_dbg", int'(idx_dbg), e.idx);
`endif
            end
        end
        accepted = 1'b0;
        if (cen && !clr && bus.pcm_valid && bus.pcm_ready) begin
            model_enc(int'($signed(bus.pcm_in)), e);
            sb.push_back(e);
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int pcm);
        bus.pcm_in    = 12'(pcm);
        bus.pcm_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (accepted) break;
        end
        check_eq("send_accept", int'(accepted), 1);
        bus.pcm_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        for (int i = 0; i < maxc && sb.size() > 0; i++) cycle();
        check_eq("drain_left", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.pcm_valid = 1'b0;
        clr           = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_pred = 0;
        m_idx  = 0;
        sb.delete();
    endtask

    task automatic check_dbg(input string tag, input int pred, input int idx);
`ifdef JT5205_ADPCM_ENC_DBG_EN
        check_eq({tag, "_pred"}, int'($signed(pred_dbg)), pred);
        check_eq({tag, "_idx"}, int'(idx_dbg), idx);
`endif
    endtask

    initial begin
        int sent;
        rst = 1'b1; cen = 1'b0; clr = 1'b0;
        bus.pcm_in = '0; bus.pcm_valid = 1'b0; bus.nib_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_nib", int'(bus.nib), 0);
        check_eq("rst_nib_valid", int'(bus.nib_valid), 0);
        check_eq("rst_pcm_ready", int'(bus.pcm_ready), 1);
        check_dbg("rst", 0, 0);
        do_reset();
        cen = 1'b1;

        // Silence from a fresh state: smallest step, index clamps at 0.
        send(0);
        drain(20);
        check_eq("zero_nib", int'(bus.nib), 0);
        check_dbg("zero", 2, 0);

        // Full-scale steps in both directions.
        do_reset();
        send(2047);
        drain(20);
        check_eq("pos_nib", int'(bus.nib), 7);
        check_dbg("pos", 30, 8);
        do_reset();
        send(-2048);
        drain(20);
        check_eq("neg_nib", int'(bus.nib), 15);
        check_dbg("neg", -30, 8);

        // Sustained full scale: index and predictor saturate.
        do_reset();
        for (int i = 0; i < 60; i++) send(2047);
        drain(20);
        check_dbg("sat", 2047, 48);

        // Output back-pressure: first nibble held, second conversion parked in UPD.
        do_reset();
        bus.nib_ready = 1'b0;
        send(100);
        send(-500);
        for (int i = 0; i < 20; i++) begin
            cycle();
            check_eq("stall_valid", int'(bus.nib_valid), 1);
            check_eq("stall_nib", int'(bus.nib), int'(sb[0].code));
        end
        check_eq("stall_pcm_ready", int'(bus.pcm_ready), 0);
        bus.nib_ready = 1'b1;
        drain(40);

        // Clear in the middle of a conversion discards it.
        do_reset();
        send(1000);
        cycle();
        clr = 1'b1;
        #1;
        check_eq("clr_pcm_ready", int'(bus.pcm_ready), 0);
        cycle();
        clr = 1'b0;
        void'(sb.pop_back());
        m_pred = 0;
        m_idx  = 0;
        for (int i = 0; i < 10; i++) cycle();
        check_eq("clr_no_nib", int'(bus.nib_valid), 0);
        check_dbg("clr", 0, 0);
        send(0);
        drain(20);
        check_eq("clr_next_nib", int'(bus.nib), 0);

        // Random samples with random cen and random consumer readiness.
        do_reset();
        sent = 0;
        for (int c = 0; c < 60000; c++) begin
            cen           = ($urandom_range(0, 9) < 7);
            bus.nib_ready = ($urandom_range(0, 3) != 0);
            if (!bus.pcm_valid && sent < 2000) begin
                if ($urandom_range(0, 3) == 0)
                    bus.pcm_in = 12'($urandom_range(0, 4095));
                else
                    bus.pcm_in = 12'(int'($signed(bus.pcm_in)) + int'($urandom_range(0, 400)) - 200);
                bus.pcm_valid = 1'b1;
            end
            cycle();
            if (accepted) begin
                bus.pcm_valid = 1'b0;
                sent++;
            end
            if (sent == 2000 && sb.size() == 0) break;
        end
        check_eq("rand_sent", sent, 2000);
        check_eq("rand_left", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
